// File: rtl/nios_gpio_pkg.sv
// nios_gpio_pkg: register offsets and edge-type encodings shared by the GPIO PIOs
package nios_gpio_pkg;
  localparam logic [1:0] GPIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] GPIO_ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] GPIO_ADDR_EDGECAP = 2'd3;
  localparam int GPIO_EDGE_RISE = 0;
  localparam int GPIO_EDGE_FALL = 1;
  localparam int GPIO_EDGE_ANY  = 2;
endpackage

// File: rtl/nios_gpio_in_if.sv
// nios_gpio_in_if: Avalon-MM slave port plus interrupt line of the GPIO input PIO
interface nios_gpio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master (output address, chipselect, read_n, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, read_n, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/nios_gpio_debounce.sv
// nios_gpio_debounce: one-bit two-flop synchronizer with optional stable-count debounce
module nios_gpio_debounce #(
  parameter int CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_stable
);
  logic r_sync1, r_sync2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end
  if (CYCLES == 0) begin : g_bypass
    assign o_stable = r_sync2;
  end else begin : g_db
    localparam int CW = $clog2(CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    // a change is accepted on the CYCLES-th consecutive cycle it persists
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign o_stable = r_stable;
  end
endmodule

// File: rtl/nios_gpio_in.sv
// nios_gpio_in: Avalon-MM GPIO input PIO with edge capture, interrupt mask and level irq
module nios_gpio_in
  import nios_gpio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = GPIO_EDGE_RISE,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  nios_gpio_in_if.slave    bus,
  input  logic [WIDTH-1:0] i_in_port
);
  logic [WIDTH-1:0] w_stable, w_edge, w_clr, w_wdata, w_sel;
  logic [WIDTH-1:0] r_prev, r_mask, r_ec;
  logic [31:0]      r_rdata;
  logic             w_wr, w_rd, w_unused;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_gpio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_pin    (i_in_port[i]),
      .o_stable (w_stable[i])
    );
  end
  assign w_wr     = bus.chipselect && !bus.write_n;
  assign w_rd     = bus.chipselect && !bus.read_n;
  assign w_wdata  = bus.writedata[WIDTH-1:0];
  assign w_unused = ^bus.writedata;
  assign w_edge = EDGE_TYPE == GPIO_EDGE_FALL ? ~w_stable & r_prev :
                  EDGE_TYPE == GPIO_EDGE_ANY  ? w_stable ^ r_prev  :
                                                w_stable & ~r_prev;
  assign w_clr  = (w_wr && bus.address == GPIO_ADDR_EDGECAP) ? w_wdata : '0;
  assign w_sel  = bus.address == GPIO_ADDR_DATA    ? w_stable :
                  bus.address == GPIO_ADDR_IRQMASK ? r_mask   :
                  bus.address == GPIO_ADDR_EDGECAP ? r_ec     : '0;
  // edge set takes priority over a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev  <= '0;
      r_mask  <= '0;
      r_ec    <= '0;
      r_rdata <= '0;
    end else begin
      r_prev  <= w_stable;
      r_ec    <= (r_ec & ~w_clr) | w_edge;
      r_rdata <= w_rd ? 32'(w_sel) : '0;
      if (w_wr && bus.address == GPIO_ADDR_IRQMASK) r_mask <= w_wdata;
    end
  end
  assign bus.readdata = r_rdata;
  assign bus.irq      = |(r_ec & r_mask);
endmodule
